// File: rtl/add_pkg.sv
// add_pkg
// Shared definitions for the four-operand mixed-signedness adder.
//   ADD_WIDTH_DEFAULT : default operand/result width
//   EXT_BITS          : guard bits added above WIDTH so the exact sum of
//                       two unsigned and two signed operands always fits
//   operand_t         : one operand/result vector at the default width
//   ext_sum_t         : exact signed sum at the default width plus guard bits
package add_pkg;

  localparam int ADD_WIDTH_DEFAULT = 64;
  localparam int EXT_BITS          = 3;

  typedef logic [ADD_WIDTH_DEFAULT-1:0]                 operand_t;
  typedef logic signed [ADD_WIDTH_DEFAULT+EXT_BITS-1:0] ext_sum_t;

endpackage

// File: rtl/csa_3to2.sv
// csa_3to2
// Purely combinational 3:2 carry-save compressor.
//   x, y, z : three addends of WIDTH bits
//   sum     : bitwise sum without carries (x ^ y ^ z)
//   carry   : bitwise majority shifted up one place
// sum + carry equals x + y + z modulo 2^WIDTH; the carry out of the top bit
// is dropped, so callers must size WIDTH to hold the true result.
module csa_3to2 #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] z,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry
);

  logic [WIDTH-1:0] majority;

  // Each bit position produces a partial sum bit and a carry that belongs
  // to the next position up.
  always_comb begin
    majority = (x & y) | (x & z) | (y & z);
    sum      = x ^ y ^ z;
    carry    = majority << 1;
  end

endmodule

// File: rtl/add_unit.sv
// add_unit
// Registered four-operand adder Z = A + B + C + D (mod 2^WIDTH) with a
// signed-overflow flag and a one-cycle valid handshake.
//   clk       : rising-edge clock
//   rst       : asynchronous active-high reset
//   in_valid  : operands valid this cycle
//   A, B      : unsigned operands
//   C, D      : two's-complement signed operands
//   out_valid : Z/ovf hold a fresh result (one cycle after in_valid)
//   Z         : signed sum, wrap-around at WIDTH bits
//   ovf       : exact sum does not fit in a signed WIDTH-bit value
// WIDTH must be at least 2.
module add_unit
  import add_pkg::*;
#(
  parameter int WIDTH = ADD_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  logic [WIDTH-1:0] D,
  output logic             out_valid,
  output logic [WIDTH-1:0] Z,
  output logic             ovf
);

  // Extended width: the worst cases are 3*2^WIDTH - 4 (positive) and
  // -2^WIDTH (negative), both of which fit in a signed WIDTH+3 vector.
  localparam int EW = WIDTH + EXT_BITS;

  logic [EW-1:0] a_ext, b_ext, c_ext, d_ext;
  logic [EW-1:0] s1, c1, s2, c2;
  logic [EW-1:0] exact_sum;
  logic [EXT_BITS:0] top_bits;
  logic          sum_ovf;

  // Widen the operands: A and B are magnitudes, C and D carry their sign.
  always_comb begin
    a_ext = {{EXT_BITS{1'b0}}, A};
    b_ext = {{EXT_BITS{1'b0}}, B};
    c_ext = {{EXT_BITS{C[WIDTH-1]}}, C};
    d_ext = {{EXT_BITS{D[WIDTH-1]}}, D};
  end

  csa_3to2 #(.WIDTH(EW)) u_csa_first (
    .x     (a_ext),
    .y     (b_ext),
    .z     (c_ext),
    .sum   (s1),
    .carry (c1)
  );

  csa_3to2 #(.WIDTH(EW)) u_csa_second (
    .x     (s1),
    .y     (c1),
    .z     (d_ext),
    .sum   (s2),
    .carry (c2)
  );

  // Final carry-propagate add, then the range test. The exact sum fits a
  // signed WIDTH-bit value only when every bit from the WIDTH-1 sign
  // position upward is identical, i.e. all zeros or all ones.
  always_comb begin
    exact_sum = s2 + c2;
    top_bits  = exact_sum[EW-1:WIDTH-1];
    sum_ovf   = !((&top_bits) || (~|top_bits));
  end

  // Output registers. Z and ovf only load on a valid edge so that operand
  // values presented while idle never reach the outputs; out_valid simply
  // follows in_valid by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Z         <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        Z   <= exact_sum[WIDTH-1:0];
        ovf <= sum_ovf;
      end
    end
  end

endmodule

// File: tb/tb_add_unit.sv
// tb_add_unit
// Self-checking bench for add_unit at the default 64-bit width. Directed
// corner cases are followed by randomized back-to-back traffic; expected
// values come from a 128-bit arithmetic reference model.
module tb_add_unit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [63:0] A, B, C, D;
  logic        out_valid;
  logic [63:0] Z;
  logic        ovf;

  int checks_total;
  int checks_passed;

  // Reference state: what the outputs should show after the latest edge.
  logic        m_valid;
  logic [63:0] m_z;
  logic        m_ovf;

  add_unit #(.WIDTH(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .C         (C),
    .D         (D),
    .out_valid (out_valid),
    .Z         (Z),
    .ovf       (ovf)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] got,
                             input logic [63:0] want);
    checks_total++;
    if (got === want) checks_passed++;
    else $display("[TB] FAIL %s: got %h expected %h", tag, got, want);
  endtask

  // Reference sum done as ordinary signed integer arithmetic on 128 bits,
  // far wider than any possible result.
  task automatic modelSum(input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] c, input logic [63:0] d,
                          output logic [63:0] z, output logic o);
    logic signed [127:0] sa, sb, sc, sd, total, maxv, minv;
    sa    = $signed({64'd0, a});
    sb    = $signed({64'd0, b});
    sc    = $signed({{64{c[63]}}, c});
    sd    = $signed({{64{d[63]}}, d});
    total = sa + sb + sc + sd;
    maxv  = (128'sd1 <<< 63) - 128'sd1;
    minv  = -(128'sd1 <<< 63);
    z     = total[63:0];
    o     = (total > maxv) || (total < minv);
  endtask

  // Drive one cycle of inputs at the falling edge, update the reference,
  // and check all outputs just after the following rising edge.
  task automatic applyStimulus(input string tag, input logic v,
                               input logic [63:0] a, input logic [63:0] b,
                               input logic [63:0] c, input logic [63:0] d);
    logic [63:0] ez;
    logic        eo;
    @(negedge clk);
    in_valid = v;
    A = a; B = b; C = c; D = d;
    if (v) begin
      modelSum(a, b, c, d, ez, eo);
      m_z   = ez;
      m_ovf = eo;
    end
    m_valid = v;
    @(posedge clk);
    #1;
    checkOutput({tag, ".valid"}, {63'd0, out_valid}, {63'd0, m_valid});
    checkOutput({tag, ".z"}, Z, m_z);
    checkOutput({tag, ".ovf"}, {63'd0, ovf}, {63'd0, m_ovf});
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  initial begin
    logic [63:0] ra, rb, rc, rd;
    checks_total  = 0;
    checks_passed = 0;
    in_valid = 1'b0;
    A = '0; B = '0; C = '0; D = '0;
    m_valid = 1'b0; m_z = '0; m_ovf = 1'b0;

    // Power-on reset.
    rst = 1'b1;
    #12;
    checkOutput("reset.valid", {63'd0, out_valid}, 64'd0);
    checkOutput("reset.z", Z, 64'd0);
    checkOutput("reset.ovf", {63'd0, ovf}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases.
    applyStimulus("mixed", 1'b1, 64'd1, 64'd2, -64'sd3, 64'd4);
    applyStimulus("wrap", 1'b1, '1, 64'd0, '1, 64'd0);
    applyStimulus("neg", 1'b1, 64'd0, 64'd5, -64'sd10, -64'sd1);
    applyStimulus("minneg", 1'b1, 64'd0, 64'd0, 64'h8000_0000_0000_0000, -64'sd1);
    applyStimulus("maxpos", 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 64'd0, 64'd0);
    applyStimulus("allmax", 1'b1, '1, '1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF);
    applyStimulus("allmin", 1'b1, 64'd0, 64'd0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);

    // Hold: a result with ovf clear, then idle cycles with moving operands.
    applyStimulus("seed", 1'b1, 64'd100, 64'd200, -64'sd50, 64'd7);
    for (int i = 0; i < 3; i++)
      applyStimulus("hold", 1'b0, rand64(), rand64(), rand64(), rand64());
    applyStimulus("seedovf", 1'b1, '1, '1, 64'd0, 64'd0);
    for (int i = 0; i < 3; i++)
      applyStimulus("holdovf", 1'b0, rand64(), rand64(), rand64(), rand64());

    // Asynchronous reset in the middle of a cycle while out_valid is high.
    applyStimulus("prerst", 1'b1, '1, 64'd3, 64'd0, 64'd0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("asyncrst.valid", {63'd0, out_valid}, 64'd0);
    checkOutput("asyncrst.z", Z, 64'd0);
    checkOutput("asyncrst.ovf", {63'd0, ovf}, 64'd0);
    m_valid = 1'b0; m_z = '0; m_ovf = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rsthold.valid", {63'd0, out_valid}, 64'd0);
    checkOutput("rsthold.z", Z, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus("postrst", 1'b1, 64'd9, 64'd1, -64'sd20, 64'd3);

    // Random back-to-back traffic, full valid then mixed valid.
    for (int i = 0; i < 30; i++) begin
      ra = rand64(); rb = rand64(); rc = rand64(); rd = rand64();
      if (i % 5 == 0) begin
        ra = ra >> 60;
        rb = rb >> 60;
      end
      applyStimulus("rand", 1'b1, ra, rb, rc, rd);
    end
    for (int i = 0; i < 20; i++)
      applyStimulus("randv", 1'($urandom_range(0, 1)), rand64(), rand64(),
                    rand64(), rand64());

    $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/add_unit.md
Name: add_unit

Overview:
- Registered four-operand 64-bit adder: Z = A + B + C + D, modulo 2^WIDTH.
- A and B are unsigned operands; C and D are two's-complement signed; Z is a signed result.
- Adds a valid handshake and a signed-overflow flag.
- Leaf arithmetic block used wherever mixed-signedness accumulation is needed.

Parameters:
- WIDTH, 64, operand and result width in bits; must be >= 2.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands valid this cycle.
- A  input  WIDTH  unsigned operand.
- B  input  WIDTH  unsigned operand.
- C  input  WIDTH  signed operand.
- D  input  WIDTH  signed operand.
- out_valid  output  1  Z/ovf hold a fresh result.
- Z  output  WIDTH  signed sum, registered.
- ovf  output  1  exact mathematical sum not representable as signed WIDTH.

Behaviour:
- Reset: rst high asynchronously forces Z=0, ovf=0, out_valid=0, regardless of clk. Effect persists while rst is held.
- Latency is exactly 1 cycle. When in_valid=1 at a rising clk edge (rst low):
  - Z <= (A + B + C + D) mod 2^WIDTH. The bit pattern is identical to plain WIDTH-bit wrap-around addition of all four raw vectors.
  - out_valid <= 1.
- in_valid=0 at an edge: out_valid <= 0; Z and ovf hold their previous values.
- No backpressure; one new result per cycle possible (throughput 1).
- ovf computation:
  - Form the exact sum S using WIDTH+3 bits.
  - A and B are zero-extended; C and D are sign-extended.
  - ovf=1 iff S < -2^(WIDTH-1) or S > 2^(WIDTH-1)-1.
  - ovf is registered together with Z.
- Arithmetic structure:
  - Two carry-save 3:2 stages reduce the four operands to sum/carry vectors at width WIDTH+3.
  - A final carry-propagate add follows.
  - The low WIDTH bits give Z; the full width gives the ovf decision.
- X/unknown inputs while in_valid=0 must not affect the outputs.
- Reset deasserting mid-stream: the first edge after deassertion behaves as a normal edge.

Decomposition:
- Shared package add_pkg:
  - ADD_WIDTH_DEFAULT = 64.
  - EXT_BITS = 3 (guard bits for the exact sum).
  - Typedefs: operand_t (logic [WIDTH-1:0]) and ext_sum_t (logic signed [WIDTH+2:0]).
- One natural sub-module: csa_3to2 (parameterized width, purely combinational). It takes x, y, z and produces sum = x^y^z and carry = majority(x,y,z) << 1. It is instantiated twice.
- Top level holds extension logic, the final adder, the overflow compare and the output registers.

Test Plan:
- Reset: assert rst asynchronously mid-cycle with out_valid=1 -> Z=0, ovf=0, out_valid=0 immediately, before the next clk edge.
- Basic mixed sign: A=1, B=2, C=-3, D=4, in_valid=1 -> next cycle Z=4, ovf=0, out_valid=1.
- Wrap case: A=all ones, B=0, C=all ones (-1), D=0 -> Z=0xFFFF_FFFF_FFFF_FFFE (-2), ovf=1 (exact sum 2^64-2).
- Negative in range: A=0, B=5, C=-10, D=-1 -> Z=-6, ovf=0. Then A=0, B=0, C=0x8000_0000_0000_0000, D=-1 -> Z=0x7FFF_FFFF_FFFF_FFFF, ovf=1.
- Hold: drive one result, then in_valid=0 with changing operands for 3 cycles -> out_valid=0, Z and ovf unchanged.
- Random: 20+ back-to-back cycles of random A/B/C/D with in_valid=1 -> each Z equals the 64-bit wrap sum one cycle later; ovf matches a reference model using the 67-bit exact sum.
